ext_bus_sequencer: RTL and testbench

- Sequences all CPU-side memory transactions onto the narrow 4-bit external bus carried on the uio pins of tt_um_toivoh_basilisc_2816.
- Arbitrates round-robin between two requesters: requester 0 is the instruction/data port, requester 1 is the host/debug port.
- Serializes header, address and write data as nibbles, then receives read data with a timeout.
- Sits between the core and the top-level pin mux.

---
 rtl/ext_bus_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/ext_bus_sequencer.sv | 127 ++++++++++++
 tb/tb_ext_bus_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the 4-bit external bus sequencer.
// The sequencer and its testbench both import this package.
package ext_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADDR,
      ST_WDATA,
      ST_WAIT,
      ST_RDATA,
      ST_RESP
   } bus_state_e;

   localparam logic       HDR_MARK        = 1'b1;
   localparam logic [3:0] START_NIBBLE    = 4'b0001;
   localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

   // Address goes out most significant nibble first; idx 0 selects [15:12].
   function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = addr[15:12];
         2'd1:    nib = addr[11:8];
         2'd2:    nib = addr[7:4];
         default: nib = addr[3:0];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       enable,
   output logic       grant_valid,
   output logic       grant_idx,
   output logic [1:0] ready
);

   logic last_grant;

   always_comb begin
      grant_valid = enable && (req != 2'b00);
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
      ready = 2'b00;
      if (grant_valid) ready = grant_idx ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (reset) last_grant <= 1'b1;
      else if (grant_valid) last_grant <= grant_idx;
   end

endmodule

// File: rtl/ext_bus_sequencer.sv
// Serialises CPU memory transactions onto the 4-bit external bus: header,
// address and write data go out as nibbles; read data comes back after a start nibble.
//
// Handshake: req_valid[i] is held by requester i until req_ready[i] pulses for
// one cycle in IDLE; request fields are captured in that same cycle.
// resp_valid pulses once to the granted requester; resp_rdata/resp_err hold after it.
module ext_bus_sequencer
   import ext_bus_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic [1:0]  resp_valid,
   output logic [7:0]  resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic [3:0]  tx_pins,
   input  logic [3:0]  rx_pins
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   bus_state_e  state;
   bus_state_e  state_next;
   logic        arb_enable;
   logic        grant_valid;
   logic        grant_idx;
   logic        g_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [1:0]  nib_cnt;
   logic [7:0]  wait_cnt;
   logic [3:0]  rd_hi;

   assign arb_enable = (state == ST_IDLE) && !reset;
   assign busy       = (state != ST_IDLE);

   rr_arbiter2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req_valid),
      .enable      (arb_enable),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .ready       (req_ready)
   );

   always_comb begin
      state_next = state;
      tx_pins    = 4'h0;
      resp_valid = 2'b00;
      case (state)
         ST_IDLE: if (grant_valid) state_next = ST_HDR;
         ST_HDR: begin
            tx_pins    = {HDR_MARK, we_q, 2'b00};
            state_next = ST_ADDR;
         end
         ST_ADDR: begin
            tx_pins = addr_nibble(addr_q, nib_cnt);
            if (nib_cnt == 2'd3) state_next = we_q ? ST_WDATA : ST_WAIT;
         end
         ST_WDATA: begin
            tx_pins = nib_cnt[0] ? wdata_q[3:0] : wdata_q[7:4];
            if (nib_cnt[0]) state_next = ST_RESP;
         end
         // A start nibble on the final wait cycle still wins over the timeout.
         ST_WAIT: begin
            if (rx_pins == START_NIBBLE) state_next = ST_RDATA;
            else if (wait_cnt == WAIT_LAST) state_next = ST_RESP;
         end
         ST_RDATA: if (nib_cnt[0]) state_next = ST_RESP;
         ST_RESP: begin
            if (!reset) resp_valid = g_q ? 2'b10 : 2'b01;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         g_q        <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 16'h0;
         wdata_q    <= 8'h0;
         nib_cnt    <= 2'd0;
         wait_cnt   <= 8'd0;
         rd_hi      <= 4'h0;
         resp_rdata <= 8'h0;
         resp_err   <= 1'b0;
      end else begin
         state    <= state_next;
         nib_cnt  <= (state_next != state) ? 2'd0 : nib_cnt + 2'd1;
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
         if (grant_valid) begin
            g_q     <= grant_idx;
            we_q    <= req_we[grant_idx];
            addr_q  <= grant_idx ? req_addr[31:16] : req_addr[15:0];
            wdata_q <= grant_idx ? req_wdata[15:8] : req_wdata[7:0];
         end
         if (state == ST_RDATA && !nib_cnt[0]) rd_hi <= rx_pins;
         if (state_next == ST_RESP) begin
            case (state)
               ST_WDATA: resp_err <= 1'b0;
               ST_WAIT: begin
                  resp_rdata <= RD_TIMEOUT_DATA;
                  resp_err   <= 1'b1;
               end
               ST_RDATA: begin
                  resp_rdata <= {rd_hi, rx_pins};
                  resp_err   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Bench for ext_bus_sequencer: a transaction-timeline model checked every cycle,
// plus directed transactions with literal expectations.
module tb_ext_bus_sequencer;

  localparam int TIMEOUT = 15;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [3:0]  tx_pins;
  logic [3:0]  rx_pins = 4'h0;

  ext_bus_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .tx_pins    (tx_pins),
    .rx_pins    (rx_pins)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (offset since accept) ----------------
  bit          m_act = 1'b0;
  int          m_off = 0;
  int          m_g = 0;
  int          m_last = 1;
  bit          m_we = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_wd = 8'h0;
  int          m_start = -1;
  logic [3:0]  m_hi = 4'h0;
  logic [7:0]  m_rdata = 8'h0;
  bit          m_err = 1'b0;

  logic [1:0]  e_ready, e_rv;
  logic [3:0]  e_tx;
  bit          e_grant, e_resp;
  int          e_g;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ready = 2'b00; e_rv = 2'b00; e_tx = 4'h0; e_grant = 0; e_resp = 0; e_g = 0;
      if (!m_act) begin
        if (!reset && req_valid != 2'b00) begin
          e_grant = 1;
          e_g = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
          e_ready = (e_g == 1) ? 2'b10 : 2'b01;
        end
      end else begin
        if (m_off == 1) e_tx = {1'b1, m_we, 2'b00};
        else if (m_off <= 5) e_tx = 4'((m_addr >> (4 * (5 - m_off))) & 16'hF);
        else if (m_we && m_off <= 7) e_tx = (m_off == 6) ? m_wd[7:4] : m_wd[3:0];
        if (m_we) e_resp = (m_off == 8);
        else if (m_start >= 0) e_resp = (m_off == m_start + 3);
        else e_resp = (m_off == 6 + TIMEOUT);
        if (e_resp && !reset) e_rv = (m_g == 1) ? 2'b10 : 2'b01;
      end
      chk("model_req_ready", req_ready, e_ready);
      chk("model_busy", busy, m_act);
      chk("model_tx_pins", tx_pins, e_tx);
      chk("model_resp_valid", resp_valid, e_rv);
      chk("model_resp_rdata", resp_rdata, m_rdata);
      chk("model_resp_err", resp_err, m_err);
      // advance the model to the next cycle
      if (reset) begin
        m_act = 0; m_last = 1; m_rdata = 8'h0; m_err = 0;
      end else if (!m_act) begin
        if (e_grant) begin
          m_act = 1; m_off = 1; m_g = e_g; m_last = e_g; m_start = -1;
          m_we = req_we[e_g];
          m_addr = (e_g == 1) ? req_addr[31:16] : req_addr[15:0];
          m_wd = (e_g == 1) ? req_wdata[15:8] : req_wdata[7:0];
        end
      end else begin
        if (m_we && m_off == 7) m_err = 0;
        if (!m_we && m_start < 0 && m_off >= 6 && m_off <= 5 + TIMEOUT) begin
          if (rx_pins == 4'h1) m_start = m_off;
          else if (m_off == 5 + TIMEOUT) begin m_rdata = 8'hFF; m_err = 1; end
        end else if (!m_we && m_start >= 0 && m_off == m_start + 1) m_hi = rx_pins;
        else if (!m_we && m_start >= 0 && m_off == m_start + 2) begin
          m_rdata = {m_hi, rx_pins}; m_err = 0;
        end
        if (e_resp) m_act = 0;
        else m_off++;
      end
    end
  end

  // ---------------- directed driver ----------------
  logic [3:0] rx_plan [0:31];
  logic [3:0] tx_plan [0:31];
  int tx_plan_len;

  task automatic clear_plans();
    for (int i = 0; i < 32; i++) begin rx_plan[i] = 4'h0; tx_plan[i] = 4'h0; end
    tx_plan_len = 0;
  endtask

  task automatic do_txn(input int g, input bit we, input logic [15:0] addr, input logic [7:0] wd,
                        input int resp_off, input logic [7:0] exp_rd, input bit exp_err, input string nm);
    req_we[g] = we;
    if (g == 0) begin req_addr[15:0] = addr; req_wdata[7:0] = wd; req_valid = 2'b01; end
    else begin req_addr[31:16] = addr; req_wdata[15:8] = wd; req_valid = 2'b10; end
    @(negedge clk);
    chk({nm, "_accept"}, req_ready, (g == 1) ? 2'b10 : 2'b01);
    for (int k = 1; k <= resp_off; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 2'b00;
      rx_pins = rx_plan[k];
      @(negedge clk);
      if (k <= tx_plan_len) chk({nm, "_tx"}, tx_pins, tx_plan[k]);
      if (k < resp_off) chk({nm, "_no_resp"}, resp_valid, 2'b00);
      else begin
        chk({nm, "_resp_valid"}, resp_valid, (g == 1) ? 2'b10 : 2'b01);
        chk({nm, "_resp_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_resp_err"}, resp_err, exp_err);
      end
    end
    @(posedge clk); #1;
    rx_pins = 4'h0;
    @(negedge clk);
    chk({nm, "_idle_tx"}, tx_pins, 4'h0);
    chk({nm, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_idle_timeout"}, busy, 1'b0);
  endtask

  // ---------------- scoreboard for arbitration order ----------------
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  initial begin
    int n;
    logic [0:0] e, a;
    clear_plans();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_rdata", resp_rdata, 8'h00);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_pins", tx_pins, 4'h0);

    // single write
    @(posedge clk); #1;
    clear_plans();
    tx_plan[1] = 4'hC; tx_plan[2] = 4'hA; tx_plan[3] = 4'h5; tx_plan[4] = 4'hC;
    tx_plan[5] = 4'h3; tx_plan[6] = 4'h7; tx_plan[7] = 4'hE; tx_plan[8] = 4'h0;
    tx_plan_len = 8;
    do_txn(0, 1'b1, 16'hA5C3, 8'h7E, 8, 8'h00, 1'b0, "write");

    // read hit, start nibble two cycles into WAIT
    @(posedge clk); #1;
    clear_plans();
    tx_plan[1] = 4'h8; tx_plan[2] = 4'h0; tx_plan[3] = 4'h1; tx_plan[4] = 4'h0;
    tx_plan[5] = 4'h2; tx_plan[6] = 4'h0; tx_plan_len = 6;
    rx_plan[8] = 4'h1; rx_plan[9] = 4'h9; rx_plan[10] = 4'h4;
    do_txn(1, 1'b0, 16'h0102, 8'h00, 11, 8'h94, 1'b0, "read_hit");

    // read timeout
    @(posedge clk); #1;
    clear_plans();
    tx_plan[1] = 4'h8; tx_plan_len = 1;
    do_txn(0, 1'b0, 16'h1234, 8'h00, 6 + TIMEOUT, 8'hFF, 1'b1, "read_timeout");

    // noise before the start nibble
    @(posedge clk); #1;
    clear_plans();
    rx_plan[6] = 4'h3; rx_plan[7] = 4'h2; rx_plan[8] = 4'h1; rx_plan[9] = 4'h5; rx_plan[10] = 4'hA;
    do_txn(0, 1'b0, 16'h00FF, 8'h00, 11, 8'h5A, 1'b0, "noise");

    // contention from reset, both held
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b11; req_we = 2'b11; req_addr = 32'h1111_2222; req_wdata = 16'h3344;
    @(posedge clk); #1 reset = 1'b0;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    n = 0;
    while (got_q.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        chk("contend_onehot", $countones(req_ready), 1);
        chk("contend_not_busy", busy, 1'b0);
        got_q.push_back(req_ready[1]);
      end
    end
    chk("contend_grant_count", got_q.size(), 4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      a = got_q.pop_front();
      chk("contend_order", a, e);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle("contend");

    // reset during ADDR of a read
    @(posedge clk); #1;
    req_we = 2'b00; req_addr[15:0] = 16'hBEEF; req_valid = 2'b01;
    @(negedge clk);
    chk("rstmid_accept", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rstmid_addr_nibble", tx_pins, 4'hE);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_tx", tx_pins, 4'h0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_rdata", resp_rdata, 8'h00);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("rstmid_no_resp", resp_valid, 2'b00);
    end
    @(posedge clk); #1;
    req_we = 2'b11; req_valid = 2'b11;
    @(negedge clk);
    chk("rstmid_tie_to_0", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle("rstmid");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
